// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg: default 640x480@60 timing, NES image geometry, colour type  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int X_OFFSET_DEF  = 64;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int IMG_W = 256;
  localparam int IMG_H = 240;
  localparam int SCALE = 2;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing: raster counters, frame-buffer addressing, 2-stage pins   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int X_OFFSET  = X_OFFSET_DEF
) (
  input  logic       pix_clk,
  input  logic       rst,
  input  logic [8:0] rgb,
  output logic [7:0] pix_ptr_x,
  output logic [7:0] pix_ptr_y,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       vblank,
  output logic       frame_tick
);

  localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_X_END   = X_OFFSET + IMG_W * SCALE;
  // Wide enough for both the line length and the window end compare value
  localparam int c_HW = $clog2(((c_H_TOTAL > c_X_END) ? c_H_TOTAL : c_X_END) + 1);
  localparam int c_VW = $clog2(c_V_TOTAL + 1);

  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_HW-1:0] c_H_VIS    = c_HW'(H_VISIBLE);
  localparam logic [c_HW-1:0] c_HS_START = c_HW'(H_VISIBLE + H_FRONT);
  localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [c_HW-1:0] c_X_LO     = c_HW'(X_OFFSET);
  localparam logic [c_HW-1:0] c_X_HI     = c_HW'(c_X_END);
  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_VIS    = c_VW'(V_VISIBLE);
  localparam logic [c_VW-1:0] c_VS_START = c_VW'(V_VISIBLE + V_FRONT);
  localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [c_HW-1:0] r_h_cnt;
  logic [c_VW-1:0] r_v_cnt;
  logic            w_visible;
  logic            w_win;
  logic            w_hs;
  logic            w_vs;
  logic            r_win;
  logic            r_hs;
  logic            r_vs;
  rgb_t            w_pix;

  assign w_pix = rgb;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + c_VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + c_HW'(1);
    end
  end

  always_comb begin
    w_visible = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
    w_win     = w_visible && (r_h_cnt >= c_X_LO) && (r_h_cnt < c_X_HI);
    w_hs      = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    w_vs      = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
  end

  // Halving the offset column and the line maps each source pixel onto 2x2 screen pixels
  assign pix_ptr_x = w_win ? 8'((r_h_cnt - c_X_LO) >> 1) : '0;
  assign pix_ptr_y = (r_v_cnt < c_V_VIS) ? 8'(r_v_cnt >> 1) : '0;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_win      <= 1'b0;
      r_hs       <= 1'b0;
      r_vs       <= 1'b0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vblank     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      r_win      <= w_win;
      r_hs       <= w_hs;
      r_vs       <= w_vs;
      vga_hs     <= ~r_hs;
      vga_vs     <= ~r_vs;
      vga_r      <= r_win ? w_pix.r : '0;
      vga_g      <= r_win ? w_pix.g : '0;
      vga_b      <= r_win ? w_pix.b : '0;
      vblank     <= (r_v_cnt >= c_V_VIS);
      frame_tick <= (r_v_cnt == c_V_VIS) && (r_h_cnt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_timing: directed checks on a full-size and a shrunken raster  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_timing;

  logic       pix_clk = 1'b0;
  logic       rst     = 1'b0;
  logic       fb_mode = 1'b1;
  logic [8:0] m_rgb;
  logic [8:0] s_rgb;
  logic [7:0] m_ptr_x, m_ptr_y, s_ptr_x, s_ptr_y;
  logic       m_hs, m_vs, s_hs, s_vs;
  logic [2:0] m_r, m_g, m_b, s_r, s_g, s_b;
  logic       m_vblank, m_ft, s_vblank, s_ft;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ft_cnt = 0;
  int vs_low = 0;
  int hs_low = 0;

  always #5 pix_clk = ~pix_clk;

  // Synchronous frame-buffer model: column 5 is magenta, the rest depends on fb_mode
  always @(posedge pix_clk)
    m_rgb <= (m_ptr_x == 8'd5) ? 9'h1C7 : (fb_mode ? 9'h1FF : 9'h000);

  assign s_rgb = 9'h1FF;

  vga_timing u_main (
    .pix_clk(pix_clk), .rst(rst), .rgb(m_rgb),
    .pix_ptr_x(m_ptr_x), .pix_ptr_y(m_ptr_y),
    .vga_hs(m_hs), .vga_vs(m_vs),
    .vga_r(m_r), .vga_g(m_g), .vga_b(m_b),
    .vblank(m_vblank), .frame_tick(m_ft)
  );

  // 60x15 raster (window from column 4) so whole frames fit in a short run
  vga_timing #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(8),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .X_OFFSET(4)
  ) u_small (
    .pix_clk(pix_clk), .rst(rst), .rgb(s_rgb),
    .pix_ptr_x(s_ptr_x), .pix_ptr_y(s_ptr_y),
    .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vblank(s_vblank), .frame_tick(s_ft)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pix_clk);
    #1;
    cyc++;
    if (s_ft) ft_cnt++;
    if (!s_vs) vs_low++;
    if (!m_hs) hs_low++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic release_rst();
    @(negedge pix_clk);
    rst    = 1'b0;
    cyc    = 0;
    ft_cnt = 0;
    vs_low = 0;
    hs_low = 0;
    #1;
  endtask

  initial begin
    // Power-on reset, applied between clock edges
    #1 rst = 1'b1;
    #2;
    check("por_hs", m_hs, 1);
    check("por_vs", m_vs, 1);
    check("por_rgb", {m_r, m_g, m_b}, 9'h000);
    check("por_vblank", m_vblank, 0);
    check("por_ft", m_ft, 0);
    check("por_ptr_x", m_ptr_x, 0);
    repeat (3) @(posedge pix_clk);
    release_rst();

    // Reset mid-line for 5 cycles
    run_to(300);
    check("pre_rst_rgb", {m_r, m_g, m_b}, 9'h1FF);
    #2 rst = 1'b1;
    #1;
    check("async_rgb", {m_r, m_g, m_b}, 9'h000);
    check("async_hs", m_hs, 1);
    check("async_ptr_x", m_ptr_x, 0);
    repeat (5) @(posedge pix_clk);
    #1;
    check("hold_vs", m_vs, 1);
    check("hold_vblank", m_vblank, 0);
    fb_mode = 1'b0;
    release_rst();

    check("rel_ptr_x", m_ptr_x, 0);
    check("rel_ptr_y", m_ptr_y, 0);
    check("rel_hs", m_hs, 1);
    run_to(5);   check("s_border_rgb", {s_r, s_g, s_b}, 9'h000);
    run_to(6);   check("s_win_rgb", {s_r, s_g, s_b}, 9'h1FF);
    run_to(8);   check("s_ptr_x", s_ptr_x, 2);
    run_to(42);  check("s_hblank_rgb", {s_r, s_g, s_b}, 9'h000);
    run_to(45);  check("s_hs_pre", s_hs, 1);
    run_to(46);  check("s_hs_fall", s_hs, 0);
    run_to(53);  check("s_hs_last", s_hs, 0);
    run_to(54);  check("s_hs_rise", s_hs, 1);
    run_to(63);  check("ptr_x_63", m_ptr_x, 0);
    run_to(64);  check("ptr_x_64", m_ptr_x, 0);
    run_to(65);  check("ptr_x_65", m_ptr_x, 0);
    run_to(66);  check("ptr_x_66", m_ptr_x, 1);
    run_to(75);  check("col5_before", {m_r, m_g, m_b}, 9'h000);
    run_to(76);  check("col5_px0", {m_r, m_g, m_b}, 9'h1C7);
    run_to(77);  check("col5_px1", {m_r, m_g, m_b}, 9'h1C7);
    run_to(78);  check("col5_after", {m_r, m_g, m_b}, 9'h000);
    run_to(100); fb_mode = 1'b1;
    run_to(120); check("s_ptr_y", s_ptr_y, 1);
    run_to(480); check("s_vblank_pre", s_vblank, 0);
                 check("s_ft_pre", s_ft, 0);
    run_to(481); check("s_vblank_rise", s_vblank, 1);
                 check("s_ft_pulse", s_ft, 1);
    run_to(482); check("s_ft_end", s_ft, 0);
                 check("s_vblank_rgb", {s_r, s_g, s_b}, 9'h000);
    run_to(575); check("ptr_x_575", m_ptr_x, 255);
    run_to(576); check("ptr_x_576", m_ptr_x, 0);
    run_to(601); check("s_vs_pre", s_vs, 1);
    run_to(602); check("s_vs_fall", s_vs, 0);
    run_to(657); check("hs_pre", m_hs, 1);
    run_to(658); check("hs_fall", m_hs, 0);
    run_to(721); check("s_vs_last", s_vs, 0);
    run_to(722); check("s_vs_rise", s_vs, 1);
    run_to(753); check("hs_last", m_hs, 0);
    run_to(754); check("hs_rise", m_hs, 1);
    run_to(800); check("ptr_y_v1", m_ptr_y, 0);
    run_to(865); check("left_border", {m_r, m_g, m_b}, 9'h000);
    run_to(866); check("left_win", {m_r, m_g, m_b}, 9'h1FF);
    run_to(900); check("s_vblank_end_pre", s_vblank, 1);
    run_to(901); check("s_vblank_fall", s_vblank, 0);
    run_to(1377); check("right_win", {m_r, m_g, m_b}, 9'h1FF);
    run_to(1378); check("right_border", {m_r, m_g, m_b}, 9'h000);
    run_to(1381); check("s_ft_frame2", s_ft, 1);
    run_to(1457); check("hs_pre_l1", m_hs, 1);
    run_to(1458); check("hs_fall_l1", m_hs, 0);
    run_to(1501); check("s_ft_count", ft_cnt, 2);
                  check("s_vs_width", vs_low, 120);
    run_to(1600); check("ptr_y_v2", m_ptr_y, 1);
                  check("hs_width_2lines", hs_low, 192);
                  check("vs_idle", m_vs, 1);
                  check("vblank_idle", m_vblank, 0);

    // Reset mid-frame: main at line 2 col 530, small at line 5 col 30
    run_to(2130);
    check("pre_rst2_m_rgb", {m_r, m_g, m_b}, 9'h1FF);
    check("pre_rst2_s_rgb", {s_r, s_g, s_b}, 9'h1FF);
    #2 rst = 1'b1;
    #1;
    check("async2_m_rgb", {m_r, m_g, m_b}, 9'h000);
    check("async2_s_rgb", {s_r, s_g, s_b}, 9'h000);
    check("async2_m_ptr_x", m_ptr_x, 0);
    check("async2_s_ptr_y", s_ptr_y, 0);
    check("async2_s_hs", s_hs, 1);
    repeat (5) @(posedge pix_clk);
    #1;
    check("hold2_s_vs", s_vs, 1);
    check("hold2_s_vblank", s_vblank, 0);
    release_rst();

    run_to(481); check("re_s_ft", s_ft, 1);
                 check("re_s_ft_count", ft_cnt, 1);
    run_to(601); check("re_s_vs_pre", s_vs, 1);
    run_to(602); check("re_s_vs_fall", s_vs, 0);
    run_to(657); check("re_hs_pre", m_hs, 1);
    run_to(658); check("re_hs_fall", m_hs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing.md
# vga_timing

Downstream consumer of the VGA frame buffer and driver of the VGA connector. It generates 640x480@60 Hz raster timing from the pixel clock and issues `pix_ptr_x`/`pix_ptr_y` read addresses to the frame buffer. It registers the returned 9-bit RRRGGGBBB colour onto the pins, aligned with hsync and vsync. The 256x240 NES image is scaled 2x to 512x480 and centred with black side borders; the block also tells the PPU side when vertical blanking is in progress.

## Interface
Parameters:
- `H_VISIBLE`, default 640: visible pixels per line.
- `H_FRONT`, default 16: horizontal front porch.
- `H_SYNC`, default 96: horizontal sync width.
- `H_BACK`, default 48: horizontal back porch.
- `V_VISIBLE`, default 480: visible lines.
- `V_FRONT`, default 10: vertical front porch.
- `V_SYNC`, default 2: vertical sync width.
- `V_BACK`, default 33: vertical back porch.
- `X_OFFSET`, default 64: first visible column of the scaled image.

Ports:
- `pix_clk` input 1: pixel clock, 25.175 MHz; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `rgb` input 9: frame-buffer colour, RRRGGGBBB; valid one cycle after the address is presented.
- `pix_ptr_x` output 8: frame-buffer column address.
- `pix_ptr_y` output 8: frame-buffer row address.
- `vga_hs` output 1: horizontal sync, active low.
- `vga_vs` output 1: vertical sync, active low.
- `vga_r`, `vga_g`, `vga_b` output 3 each: colour to the DAC.
- `vblank` output 1: high while the raster is outside visible lines.
- `frame_tick` output 1: one-cycle pulse at the start of vblank.

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = 800; it wraps to 0.
  - `v_cnt` runs 0..V_TOTAL-1, where V_TOTAL = 525; it increments only when `h_cnt` wraps and wraps to 0 after 524.
  - One frame is 420000 cycles.
- Regions:
  - Visible when `h_cnt < 640` and `v_cnt < 480`.
  - Image window is visible and `X_OFFSET <= h_cnt < X_OFFSET+512`.
  - The border (visible but outside the window) is driven black.
- Sync:
  - hs is asserted for `656 <= h_cnt < 752`.
  - vs is asserted for `490 <= v_cnt < 492`.
- Addresses (combinational from counters):
  - `pix_ptr_x = (h_cnt - X_OFFSET) >> 1`, truncated to 8 bits, inside the window; 0 outside.
  - `pix_ptr_y = v_cnt >> 1` for `v_cnt < 480`; 0 otherwise.
  - Each source pixel therefore covers 2x2 screen pixels.
- Pipeline: stage 1 registers `win`, `hs` and `vs` alongside the frame-buffer read. Stage 2 registers the pins:
  - `vga_r/g/b` = `rgb[8:6]/[5:3]/[2:0]` if stage-1 `win`, else 0.
  - `vga_hs`/`vga_vs` = inverted stage-1 `hs`/`vs`.
- `vblank` is registered and equals `v_cnt >= 480`. `frame_tick` is registered and is 1 for the single cycle where `v_cnt == 480 && h_cnt == 0`.
- Reset values:
  - Counters 0.
  - `vga_hs=1`, `vga_vs=1`, `vga_r/g/b=0`.
  - `vblank=0`, `frame_tick=0`.
  - Pipeline `win`/`hs`/`vs` flags 0.
  - `pix_ptr_x/y=0`.
- Reset mid-frame: all of the above is forced immediately (asynchronously). After deassertion the raster restarts at (0,0) on the first `pix_clk` edge, with no sync or colour glitch beyond the forced idle levels.
- Parameter legality: `X_OFFSET + 512 <= H_VISIBLE` and `V_VISIBLE == 480`; other values are unsupported.

## Timing
- Pin latency is 2 cycles from counter state, for colour, hs and vs alike. Sync and colour stay mutually aligned.
- `vblank` and `frame_tick` have 1-cycle latency from counter state.
- Frame-buffer contract: address at edge N, `rgb` valid before edge N+1. No other handshake.
- Counter wrap on line 524, column 799 goes to (0,0) in one cycle, with no idle cycle.
- The PPU may write the frame buffer at any time; tearing-free updates are the PPU's job, gated by `vblank`/`frame_tick`.

## Structure
- Package `vga_pkg`:
  - default timing constants;
  - derived `H_TOTAL`/`V_TOTAL`;
  - `IMG_W=256`, `IMG_H=240`, `SCALE=2`;
  - a packed typedef for the RRRGGGBBB colour.
- No sub-module is needed. The counters, decode and 2-stage pipeline live in the one module, about 150-200 lines.

## Test plan
- Reset held 5 cycles mid-line → `vga_hs=1`, `vga_vs=1`, colour 0, `vblank=0`. After release, `pix_ptr_x=0` and the first `vga_hs` low occurs at cycle 656+2.
- Free run 2 frames → hs low width 96, hs period 800, vs low width 2 lines, vs period 420000 cycles, `frame_tick` exactly once per 420000.
- Address map → `h_cnt` 63 gives ptr 0 (border), 64→0, 65→0, 66→1, 575→255, 576→0 (border). `v_cnt` 0,1→0, 479→239, 480→0.
- Frame-buffer model returns `rgb=9'h1C7` for column 5 → the pins show `vga_r=7`, `vga_g=0`, `vga_b=7` for exactly 2 screen pixels, 2 cycles after `h_cnt` hits 74.
- Border and blank with model driving `rgb=9'h1FF` → `vga_r/g/b=0` for `h_cnt<64`, `h_cnt≥576` and all lines ≥480, at pin-aligned cycles.
- Reset asserted at `v_cnt=300`, `h_cnt=400` → outputs forced idle asynchronously. The next frame then starts at (0,0) with correct sync spacing.
